// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Serial transmit stage fed by the load/store unit. Each accepted byte goes out
// on a single UART line as: start bit (0), 8 data bits LSB first, an optional
// parity bit, then one or two stop bits (1). A one-cycle tx_done pulse follows
// the last stop bit so the LSU can step to its next byte.
//
// Request handshake: tx_start is an active-low request qualified only while
// tx_busy is low (IDLE). A request is accepted on the first rising clk edge at
// which the block is in IDLE and tx_start is low. tx_data is captured on that
// same edge. Both inputs are ignored from acceptance until the block is back in
// IDLE, and this includes the DONE cycle.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//   PARITY        0 = none, 1 = even, 2 = odd
//   STOP_BITS     1 or 2
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-low reset
//   tx_start  in   active-low transmit request (sampled in IDLE only)
//   tx_data   in   [7:0] byte to send, latched on acceptance
//   tx        out  serial line, idles high
//   tx_done   out  one-cycle pulse after the final stop bit
//   tx_busy   out  high from acceptance through the DONE cycle
//
// All outputs are registered. The FSM state is held in state_q so that
// checkers can bind to it directly.
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 87,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_done,
  output logic       tx_busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY_BIT,
    STOP,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               parity_q, parity_d;
  logic               tx_q, tx_d;
  logic               tx_done_q, tx_done_d;
  logic               tx_busy_q, tx_busy_d;

  logic               baud_last;
  logic [2:0]         bit_next;

  assign baud_last = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
  assign bit_next  = bit_q + 3'd1;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
      tx_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      tx_done_q <= tx_done_d;
      tx_busy_q <= tx_busy_d;
    end
  end

  // Next-state logic. Because the outputs are registered, tx_d is the line
  // level for the state being entered, so tx changes on the same edge as the
  // state does.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tx_d      = tx_q;
    tx_done_d = 1'b0;
    tx_busy_d = tx_busy_q;

    unique case (state_q)
      IDLE: begin
        baud_d    = '0;
        bit_d     = '0;
        tx_d      = 1'b1;
        tx_busy_d = 1'b0;
        if (!tx_start) begin
          shift_d   = tx_data;
          // Even parity is the XOR of the data bits. Odd parity is its inverse.
          parity_d  = (^tx_data) ^ (PARITY == 2);
          tx_busy_d = 1'b1;
          tx_d      = 1'b0;
          state_d   = START;
        end
      end

      START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            // The bit counter is reused to count stop bits.
            bit_d = '0;
            if (PARITY != 0) begin
              tx_d    = parity_q;
              state_d = PARITY_BIT;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            bit_d = bit_next;
            tx_d  = shift_q[bit_next];
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      PARITY_BIT: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      STOP: begin
        tx_d = 1'b1;
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'(STOP_BITS - 1)) begin
            bit_d     = '0;
            tx_done_d = 1'b1;
            state_d   = DONE;
          end else begin
            bit_d = bit_next;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      DONE: begin
        // The upstream stage still presents the old byte during this cycle,
        // so the request is deliberately ignored here.
        baud_d    = '0;
        tx_d      = 1'b1;
        tx_busy_d = 1'b0;
        state_d   = IDLE;
      end

      default: begin
        baud_d    = '0;
        bit_d     = '0;
        tx_d      = 1'b1;
        tx_busy_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  assign tx      = tx_q;
  assign tx_done = tx_done_q;
  assign tx_busy = tx_busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Four serializer instances share clk and reset. All of them run at 4 clk per
// bit and differ in their framing:
//   dut0: no parity,   1 stop bit
//   dut1: even parity, 1 stop bit
//   dut2: odd parity,  1 stop bit
//   dut3: even parity, 2 stop bits
// Drivers change inputs 1 time unit after posedge. The monitor samples at
// negedge. The expected queue holds {dut index, byte} and is filled when a
// request is issued. The monitor pops one entry at each observed start bit,
// builds the expected frame from the byte, and checks every cycle of that
// frame plus the tx_done cycle that follows it.
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;

  localparam int CLKS = 4;
  localparam int NDUT = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NDUT-1:0] tx_start;
  logic [7:0]      tx_data [NDUT];
  logic [NDUT-1:0] tx;
  logic [NDUT-1:0] tx_done;
  logic [NDUT-1:0] tx_busy;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];

  // monitor state
  int          pos       [NDUT];
  logic [15:0] fbits     [NDUT];
  int          fn        [NDUT];
  int          ferr      [NDUT];
  logic [7:0]  fbyte     [NDUT];
  int          last_done [NDUT];
  int          gap       [NDUT];
  int          cyc = 0;
  logic        rst_prev = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    uart_tx_serializer #(
      .CLKS_PER_BIT (CLKS),
      .PARITY       ((g == 3) ? 1 : g),
      .STOP_BITS    ((g == 3) ? 2 : 1)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .tx_start (tx_start[g]),
      .tx_data  (tx_data[g]),
      .tx       (tx[g]),
      .tx_done  (tx_done[g]),
      .tx_busy  (tx_busy[g])
    );
  end

  function automatic int par_of(input int idx);
    return (idx == 3) ? 1 : idx;
  endfunction

  function automatic int stops_of(input int idx);
    return (idx == 3) ? 2 : 1;
  endfunction

  // Reference frame: a list of line levels, one per serial bit slot.
  function automatic void model_frame(input int idx, input logic [7:0] d,
                                      output logic [15:0] bits, output int n);
    int ones;
    bits = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
    n = 9;
    ones = $countones(d);
    if (par_of(idx) == 1) begin
      bits[n] = ((ones % 2) == 1);
      n++;
    end else if (par_of(idx) == 2) begin
      bits[n] = ((ones % 2) == 0);
      n++;
    end
    for (int s = 0; s < stops_of(idx); s++) begin
      bits[n] = 1'b1;
      n++;
    end
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [9:0]  e;
    logic [15:0] fb;
    int          fnn;
    for (int i = 0; i < NDUT; i++) begin
      pos[i] = -1;
      last_done[i] = -1;
      gap[i] = -1;
      ferr[i] = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NDUT; i++) begin
        if (!rst_prev) begin
          // A posedge with reset low has just happened.
          checks++;
          if (tx[i] !== 1'b1 || tx_done[i] !== 1'b0 || tx_busy[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals dut%0d: tx=%b done=%b busy=%b, required 1/0/0",
                     i, tx[i], tx_done[i], tx_busy[i]);
          end
          pos[i] = -1;
          last_done[i] = -1;
        end else begin
          if (pos[i] < 0) begin
            checks++;
            if (tx_done[i] !== 1'b0 || (tx[i] === 1'b1 && tx_busy[i] !== 1'b0)) begin
              errors++;
              $display("FAIL idle_outputs dut%0d: tx=%b done=%b busy=%b, required done=0 busy=0",
                       i, tx[i], tx_done[i], tx_busy[i]);
            end
            if (tx[i] === 1'b0) begin
              checks++;
              if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame dut%0d: start bit seen, required no frame", i);
              end else begin
                e = exp_q.pop_front();
                if (int'(e[9:8]) != i) begin
                  errors++;
                  $display("FAIL frame_dut: frame on dut%0d, required dut%0d", i, e[9:8]);
                end
                model_frame(i, e[7:0], fb, fnn);
                fbits[i] = fb;
                fn[i]    = fnn;
                fbyte[i] = e[7:0];
                ferr[i]  = 0;
                pos[i]   = 0;
                gap[i]   = (last_done[i] >= 0) ? (cyc - last_done[i]) : -1;
              end
            end
          end
          if (pos[i] >= 0) begin
            if (pos[i] < fn[i] * CLKS) begin
              if (tx[i] !== fbits[i][pos[i] / CLKS] || tx_busy[i] !== 1'b1 ||
                  tx_done[i] !== 1'b0)
                ferr[i]++;
              pos[i]++;
            end else begin
              checks++;
              if (ferr[i] != 0) begin
                errors++;
                $display("FAIL frame_bits dut%0d byte %h: bad_samples=%0d, required 0",
                         i, fbyte[i], ferr[i]);
              end
              checks++;
              if (tx_done[i] !== 1'b1 || tx[i] !== 1'b1 || tx_busy[i] !== 1'b1) begin
                errors++;
                $display("FAIL done_pulse dut%0d: tx=%b done=%b busy=%b, required 1/1/1",
                         i, tx[i], tx_done[i], tx_busy[i]);
              end
              last_done[i] = cyc;
              pos[i] = -1;
            end
          end
        end
      end
      rst_prev = reset;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int idx, input logic [7:0] d);
    int n;
    n = 0;
    while (tx_busy[idx] !== 1'b0 && n < 200) begin
      wait_cycles(1);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL send_timeout dut%0d: busy=%b, required 0", idx, tx_busy[idx]);
    end
    tx_data[idx]  = d;
    tx_start[idx] = 1'b0;
    exp_q.push_back({2'(idx), d});
    wait_cycles(1);
    tx_start[idx] = 1'b1;
  endtask

  task automatic wait_idle(input int idx);
    int n;
    n = 0;
    while (!(tx_busy[idx] === 1'b0 && pos[idx] < 0 && exp_q.size() == 0) && n < 500) begin
      wait_cycles(1);
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL idle_timeout dut%0d: pending=%0d, required 0", idx, exp_q.size());
    end
  endtask

  task automatic wait_done(input int idx);
    int n;
    n = 0;
    while (tx_done[idx] !== 1'b1 && n < 200) begin
      wait_cycles(1);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL done_timeout dut%0d: done=%b, required 1", idx, tx_done[idx]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset    = 1'b0;
    tx_start = {NDUT{1'b1}};
    tx_start[0] = 1'b0;
    for (int i = 0; i < NDUT; i++) tx_data[i] = 8'h00;

    // Reset held for 3 cycles with a pending request. Nothing may start.
    wait_cycles(3);
    reset      = 1'b1;
    tx_data[0] = 8'h3C;
    exp_q.push_back({2'd0, 8'h3C});
    wait_cycles(1);
    tx_start[0] = 1'b1;
    wait_idle(0);

    // Single byte, no parity.
    send(0, 8'hA5);
    wait_idle(0);

    // Parity slot: 0x07 has three ones.
    send(1, 8'h07);
    wait_idle(1);
    send(2, 8'h07);
    wait_idle(2);
    send(3, 8'h07);
    wait_idle(3);

    // LSU-style back-to-back: the request stays low, and the data changes one
    // cycle after each tx_done.
    tx_data[0]  = 8'h01;
    tx_start[0] = 1'b0;
    exp_q.push_back({2'd0, 8'h01});
    wait_done(0);
    wait_cycles(1);
    tx_data[0] = 8'h2C;
    exp_q.push_back({2'd0, 8'h2C});
    wait_cycles(1);
    wait_done(0);
    wait_cycles(1);
    tx_start[0] = 1'b1;
    wait_idle(0);
    checks++;
    if (gap[0] != 2) begin
      errors++;
      $display("FAIL b2b_gap dut0: idle_high_cycles=%0d, required 2", gap[0]);
    end

    // Data change mid-frame must not reach the line.
    send(0, 8'h00);
    wait_cycles(12);
    tx_data[0] = 8'hFF;
    wait_idle(0);

    // Reset during data bit 3. The frame is dropped, and a clean frame follows.
    send(0, 8'h96);
    wait_cycles(17);
    reset = 1'b0;
    wait_cycles(1);
    reset = 1'b1;
    wait_cycles(2);
    send(0, 8'h5A);
    wait_idle(0);

    // Randomized traffic on every instance.
    for (int d = 0; d < NDUT; d++) begin
      for (int k = 0; k < 6; k++) begin
        send(d, 8'($urandom_range(0, 255)));
        wait_cycles($urandom_range(0, 3));
      end
      wait_idle(d);
    end

    wait_cycles(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected: pending=%0d, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
